adpcm_main_mul_share_arb: RTL and testbench

Round-robin controller that time-shares one unsigned multiplier instance (`A_WIDTH` x `B_WIDTH` -> `P_WIDTH`, combinational, zero stages) among `NUM_REQ` requesters inside `adpcm_main`.

- The block accepts one operand pair per cycle through per-requester valid/ready handshakes.
- It registers the operands onto the multiplier inputs.
- It captures the product one cycle later and returns it with the winning requester's index.
- It sits between the encoder/decoder filter loops and the single shared multiplier, replacing per-loop multiplier copies.

---
 rtl/adpcm_main_mul_share_arb.sv | 113 +++++++++++
 tb/tb_adpcm_main_mul_share_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_main_mul_share_arb.sv
// Round-robin arbiter sharing one combinational unsigned multiplier among NUM_REQ requesters.
// Two-register pipeline: S1 drives the multiplier operands, S2 holds the returned product.
module adpcm_main_mul_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 15,
    parameter int B_WIDTH  = 10,
    parameter int P_WIDTH  = 24,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [A_WIDTH-1:0]         mul_din0,
    output logic [B_WIDTH-1:0]         mul_din1,
    input  logic [P_WIDTH-1:0]         mul_dout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [P_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]        rsp_id,
    output logic                       busy
);

    logic                s1_valid;
    logic [ID_WIDTH-1:0] s1_id;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_next;
    logic [ID_WIDTH-1:0] win;
    logic [ID_WIDTH-1:0] cand;
    logic                hit;
    logic                grant;
    logic                s2_adv;
    logic                s1_free;
    logic [A_WIDTH-1:0]  a_sel;
    logic [B_WIDTH-1:0]  b_sel;

    assign s2_adv  = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free = ~s1_valid | s2_adv;
    assign grant   = hit & s1_free & ~ap_rst;
    assign busy    = s1_valid | rsp_valid;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        hit  = 1'b0;
        win  = ptr;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!hit && req_valid[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == ID_WIDTH'(k)) begin
                a_sel = req_a[k*A_WIDTH +: A_WIDTH];
                b_sel = req_b[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    assign ptr_next = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + ID_WIDTH'(1);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            mul_din0  <= '0;
            mul_din1  <= '0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (s1_free) begin
                if (grant) begin
                    mul_din0 <= a_sel;
                    mul_din1 <= b_sel;
                    s1_id    <= win;
                    s1_valid <= 1'b1;
                    ptr      <= ptr_next;
                end else begin
                    // Zero the operands when idle so the multiplier inputs stay quiet.
                    mul_din0 <= '0;
                    mul_din1 <= '0;
                    s1_valid <= 1'b0;
                end
            end
            if (s2_adv) begin
                rsp_data  <= mul_dout;
                rsp_id    <= s1_id;
                rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adpcm_main_mul_share_arb.sv
// Bench for adpcm_main_mul_share_arb: directed vector table, a hand sequence for operand
// quieting, and randomized traffic checked against a queue-based reference model.
module tb_adpcm_main_mul_share_arb;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int BW = 10;
    localparam int PW = 24;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a = '0;
    logic [N*BW-1:0] req_b = '0;
    logic [AW-1:0]   mul_din0;
    logic [BW-1:0]   mul_din1;
    logic [PW-1:0]   mul_dout;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [PW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    logic [AW+BW-1:0] full_prod;
    assign full_prod = {{BW{1'b0}}, mul_din0} * {{AW{1'b0}}, mul_din1};
    assign mul_dout  = full_prod[PW-1:0];

    always #5 ap_clk = ~ap_clk;

    adpcm_main_mul_share_arb #(
        .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [14:0] a;
        logic [9:0]  b;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic        chk_data;
        logic [23:0] e_data;
        logic [1:0]  e_id;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [3:0] valid, logic [14:0] a, logic [9:0] b,
                                logic rdy, logic [3:0] er, logic erv, logic cd,
                                logic [23:0] ed, logic [1:0] eid);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a = a; v.b = b; v.rdy = rdy;
        v.e_ready = er; v.e_rv = erv; v.chk_data = cd; v.e_data = ed; v.e_id = eid;
        return v;
    endfunction

    // Requester i presents (a+i, b) in the directed table.
    task automatic set_ops(input logic [14:0] a, input logic [9:0] b);
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = a + 15'(i);
            req_b[i*BW +: BW] = b;
        end
    endtask

    vec_t tbl[$];

    typedef struct {
        int     id;
        longint a;
        longint b;
        int     t;
    } ent_t;

    ent_t   q[$];
    int     mptr;
    int     ecount;
    logic   pv[N];
    longint pa[N];
    longint pb[N];

    initial begin
        //                 rst  valid  a      b     rdy  ready rv chk data      id
        tbl.push_back(mk(1, 4'hF, 0,     0,    1, 4'h0, 0, 1, 0,        0)); // reset state
        tbl.push_back(mk(0, 4'h1, 3,     5,    1, 4'h1, 0, 0, 0,        0)); // single request
        tbl.push_back(mk(0, 4'h0, 3,     5,    1, 4'h0, 0, 0, 0,        0));
        tbl.push_back(mk(0, 4'h0, 3,     5,    1, 4'h0, 1, 1, 15,       0));
        tbl.push_back(mk(0, 4'h0, 3,     5,    1, 4'h0, 0, 0, 0,        0));
        tbl.push_back(mk(1, 4'hF, 100,   7,    1, 4'h0, 0, 1, 15,       0)); // reset, ptr->0
        tbl.push_back(mk(0, 4'hF, 100,   7,    1, 4'h1, 0, 0, 0,        0)); // round robin
        tbl.push_back(mk(0, 4'hF, 100,   7,    1, 4'h2, 0, 0, 0,        0));
        tbl.push_back(mk(0, 4'hF, 100,   7,    1, 4'h4, 1, 1, 700,      0));
        tbl.push_back(mk(0, 4'hF, 100,   7,    1, 4'h8, 1, 1, 707,      1));
        tbl.push_back(mk(0, 4'hF, 100,   7,    1, 4'h1, 1, 1, 714,      2));
        tbl.push_back(mk(0, 4'h0, 100,   7,    1, 4'h0, 1, 1, 721,      3));
        tbl.push_back(mk(0, 4'h0, 100,   7,    1, 4'h0, 1, 1, 700,      0));
        tbl.push_back(mk(0, 4'h0, 100,   7,    1, 4'h0, 0, 1, 700,      0));
        tbl.push_back(mk(0, 4'h1, 32767, 1023, 1, 4'h1, 0, 0, 0,        0)); // width edge
        tbl.push_back(mk(0, 4'h1, 0,     1023, 1, 4'h1, 0, 0, 0,        0));
        tbl.push_back(mk(0, 4'h0, 0,     1023, 1, 4'h0, 1, 1, 16743425, 0));
        tbl.push_back(mk(0, 4'h0, 0,     1023, 1, 4'h0, 1, 1, 0,        0));
        tbl.push_back(mk(0, 4'h0, 0,     1023, 1, 4'h0, 0, 1, 0,        0));
        tbl.push_back(mk(0, 4'hF, 200,   3,    0, 4'h2, 0, 0, 0,        0)); // backpressure
        tbl.push_back(mk(0, 4'hF, 200,   3,    0, 4'h4, 0, 0, 0,        0));
        tbl.push_back(mk(0, 4'hF, 200,   3,    0, 4'h0, 1, 1, 603,      1));
        tbl.push_back(mk(0, 4'hF, 200,   3,    0, 4'h0, 1, 1, 603,      1));
        tbl.push_back(mk(0, 4'hF, 200,   3,    0, 4'h0, 1, 1, 603,      1));
        tbl.push_back(mk(0, 4'hF, 200,   3,    1, 4'h8, 1, 1, 603,      1));
        tbl.push_back(mk(0, 4'h0, 200,   3,    1, 4'h0, 1, 1, 606,      2));
        tbl.push_back(mk(0, 4'h0, 200,   3,    1, 4'h0, 1, 1, 609,      3));
        tbl.push_back(mk(0, 4'h0, 200,   3,    1, 4'h0, 0, 1, 609,      3));
        tbl.push_back(mk(0, 4'h4, 10,    2,    1, 4'h4, 0, 0, 0,        0)); // wrap and skip
        tbl.push_back(mk(0, 4'hA, 10,    2,    1, 4'h8, 0, 0, 0,        0));
        tbl.push_back(mk(0, 4'h2, 10,    2,    1, 4'h2, 1, 1, 24,       2));
        tbl.push_back(mk(0, 4'h0, 10,    2,    1, 4'h0, 1, 1, 26,       3));
        tbl.push_back(mk(0, 4'h0, 10,    2,    1, 4'h0, 1, 1, 22,       1));
        tbl.push_back(mk(0, 4'h0, 10,    2,    1, 4'h0, 0, 1, 22,       1));
        tbl.push_back(mk(0, 4'hF, 50,    1,    0, 4'h4, 0, 0, 0,        0)); // reset with S1+S2 full
        tbl.push_back(mk(0, 4'hF, 50,    1,    0, 4'h8, 0, 0, 0,        0));
        tbl.push_back(mk(1, 4'hF, 50,    1,    0, 4'h0, 1, 1, 52,       2));
        tbl.push_back(mk(0, 4'h0, 50,    1,    1, 4'h0, 0, 1, 0,        0));
        tbl.push_back(mk(0, 4'h0, 50,    1,    1, 4'h0, 0, 1, 0,        0));
        tbl.push_back(mk(0, 4'h0, 50,    1,    1, 4'h0, 0, 1, 0,        0));

        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge ap_clk);
            ap_rst    = tbl[i].rst;
            req_valid = tbl[i].valid;
            rsp_ready = tbl[i].rdy;
            set_ops(tbl[i].a, tbl[i].b);
            #1;
            chk($sformatf("row%0d_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("row%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
            if (tbl[i].chk_data) begin
                chk($sformatf("row%0d_rsp_data", i), rsp_data, tbl[i].e_data);
                chk($sformatf("row%0d_rsp_id", i), rsp_id, tbl[i].e_id);
            end
        end

        // Operand registers load on grant, then return to zero when nothing is granted.
        @(negedge ap_clk);
        req_valid = 4'h1; rsp_ready = 1'b1; set_ops(3, 5);
        #1;
        chk("hand_busy_idle", busy, 0);
        chk("hand_din0_idle", mul_din0, 0);
        chk("hand_ready", req_ready, 4'h1);
        @(negedge ap_clk);
        req_valid = 4'h0;
        #1;
        chk("hand_din0_loaded", mul_din0, 3);
        chk("hand_din1_loaded", mul_din1, 5);
        chk("hand_busy_s1", busy, 1);
        @(negedge ap_clk);
        #1;
        chk("hand_din0_quiet", mul_din0, 0);
        chk("hand_din1_quiet", mul_din1, 0);
        chk("hand_busy_s2", busy, 1);
        chk("hand_rsp_data", rsp_data, 15);
        @(negedge ap_clk);
        #1;
        chk("hand_busy_done", busy, 0);

        // Randomized traffic against the reference model.
        q.delete();
        mptr = 0;
        ecount = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pa[i] = 0; pb[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic   r;
            logic   vis;
            logic   can;
            logic   any;
            int     w;
            logic [3:0] exp_ready;
            longint ea;
            longint eb;
            @(negedge ap_clk);
            r = (cyc == 0) || ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = longint'($urandom_range(0, 32767));
                    pb[i] = longint'($urandom_range(0, 1023));
                end
                req_valid[i]      = pv[i];
                req_a[i*AW +: AW] = AW'(pa[i]);
                req_b[i*BW +: BW] = BW'(pb[i]);
            end
            ap_rst    = r;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            vis = (q.size() > 0) && (ecount >= q[0].t + 1);
            if (cyc > 0) begin
                chk("rand_rsp_valid", rsp_valid, vis);
                chk("rand_busy", busy, q.size() != 0);
                if (vis) begin
                    chk("rand_rsp_data", rsp_data, (q[0].a * q[0].b) % (longint'(1) << PW));
                    chk("rand_rsp_id", rsp_id, q[0].id);
                end
                ea = 0;
                eb = 0;
                if (q.size() == 2 || (q.size() == 1 && !vis)) begin
                    ea = q[q.size()-1].a;
                    eb = q[q.size()-1].b;
                end
                chk("rand_din0", mul_din0, ea);
                chk("rand_din1", mul_din1, eb);
            end
            any = 1'b0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (!any && pv[c]) begin
                    any = 1'b1;
                    w = c;
                end
            end
            can = !r && (q.size() < 2 || rsp_ready);
            exp_ready = '0;
            if (can && any) exp_ready[w] = 1'b1;
            chk("rand_ready", req_ready, exp_ready);

            if (r) begin
                q.delete();
                mptr = 0;
            end else begin
                if (vis && rsp_ready) void'(q.pop_front());
                if (can && any) begin
                    ent_t e;
                    e.id = w; e.a = pa[w]; e.b = pb[w]; e.t = ecount + 1;
                    q.push_back(e);
                    pv[w] = 1'b0;
                    mptr = (w + 1) % N;
                end
            end
            ecount++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
